// File: rtl/control_fsm_pkg.sv
// Shared opcode, ALU function and state definitions for the multi-cycle control unit.
package control_fsm_pkg;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_SW   = 6'b011111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_BCOND = 3'd3,
    CLS_BRA   = 3'd4,
    CLS_ILL   = 3'd5
  } instr_class_e;

  typedef enum logic [8:0] {
    S_FETCH  = 9'b000000001,
    S_DECODE = 9'b000000010,
    S_EXEC   = 9'b000000100,
    S_MEM_RD = 9'b000001000,
    S_MEM_WR = 9'b000010000,
    S_WB_ALU = 9'b000100000,
    S_WB_MEM = 9'b001000000,
    S_BR     = 9'b010000000,
    S_NOP    = 9'b100000000
  } state_e;

endpackage

// File: rtl/control_fsm_instr_class_dec.sv
// Combinational opcode classifier: instruction class, ALU op and operand/register-B selects.
module instr_class_dec
  import control_fsm_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [3:0]   funct_i,
  output instr_class_e cls_o,
  output logic [3:0]   func_o,
  output logic         alu_imm_o,
  output logic         rf_b_rt_o
);

  always_comb begin
    cls_o     = CLS_ILL;
    func_o    = FN_ADD;
    alu_imm_o = 1'b0;
    rf_b_rt_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        cls_o  = CLS_ALU;
        func_o = funct_i;
      end
      OP_LI, OP_LUI, OP_ADDI: begin
        cls_o     = CLS_ALU;
        alu_imm_o = 1'b1;
        rf_b_rt_o = 1'b1;
      end
      OP_ANDI: begin
        cls_o     = CLS_ALU;
        func_o    = FN_AND;
        alu_imm_o = 1'b1;
        rf_b_rt_o = 1'b1;
      end
      OP_ORI: begin
        cls_o     = CLS_ALU;
        func_o    = FN_OR;
        alu_imm_o = 1'b1;
        rf_b_rt_o = 1'b1;
      end
      OP_LB, OP_LW: begin
        cls_o     = CLS_LOAD;
        alu_imm_o = 1'b1;
      end
      OP_SB, OP_SW: begin
        cls_o     = CLS_STORE;
        alu_imm_o = 1'b1;
        rf_b_rt_o = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls_o     = CLS_BCOND;
        func_o    = FN_SUB;
        rf_b_rt_o = 1'b1;
      end
      OP_B: begin
        cls_o = CLS_BRA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences each instruction FETCH..WB and pulses the PC enable once at its end.
module control_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        en,
  output logic        PC_sel,
  output logic        RFsel_wr,
  output logic        RFsel_B,
  output logic        RFwr_en,
  output logic        ALUsel_B,
  output logic        MEMwr_en,
  output logic [3:0]  func
);

  import control_fsm_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e       state_q;
  instr_class_e cls_q;
  logic [5:0]   op_q;
  logic [3:0]   cnt_q;
  logic [3:0]   func_q;
  logic         en_q, rfwr_q, memwr_q, rfsel_wr_q, alusel_b_q, rfsel_b_q;

  instr_class_e dec_cls;
  logic [3:0]   dec_func;
  logic         dec_alu_imm, dec_rf_b_rt;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^instr[25:4];

  instr_class_dec u_dec (
    .opcode_i  (instr[31:26]),
    .funct_i   (instr[3:0]),
    .cls_o     (dec_cls),
    .func_o    (dec_func),
    .alu_imm_o (dec_alu_imm),
    .rf_b_rt_o (dec_rf_b_rt)
  );

  // Strobes are registered on entry to the state in which they must be seen,
  // so each is one cycle wide and a reset at that edge suppresses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cls_q      <= CLS_ALU;
      op_q       <= '0;
      cnt_q      <= '0;
      func_q     <= '0;
      en_q       <= 1'b0;
      rfwr_q     <= 1'b0;
      memwr_q    <= 1'b0;
      rfsel_wr_q <= 1'b0;
      alusel_b_q <= 1'b0;
      rfsel_b_q  <= 1'b0;
    end else begin
      en_q       <= 1'b0;
      rfwr_q     <= 1'b0;
      memwr_q    <= 1'b0;
      rfsel_wr_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          state_q    <= S_DECODE;
          op_q       <= instr[31:26];
          cls_q      <= dec_cls;
          func_q     <= dec_func;
          alusel_b_q <= dec_alu_imm;
          rfsel_b_q  <= dec_rf_b_rt;
        end
        S_DECODE: begin
          case (cls_q)
            CLS_BRA: begin
              state_q <= S_BR;
              en_q    <= 1'b1;
            end
            CLS_ILL: begin
              state_q <= S_NOP;
              en_q    <= 1'b1;
            end
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          cnt_q <= CNT_INIT;
          case (cls_q)
            CLS_LOAD:  state_q <= S_MEM_RD;
            CLS_STORE: begin
              state_q <= S_MEM_WR;
              memwr_q <= 1'b1;
              en_q    <= (MEM_LAT == 1);
            end
            CLS_BCOND: begin
              state_q <= S_BR;
              en_q    <= 1'b1;
            end
            default: begin
              state_q <= S_WB_ALU;
              en_q    <= 1'b1;
              rfwr_q  <= 1'b1;
            end
          endcase
        end
        S_MEM_RD: begin
          if (cnt_q == '0) begin
            state_q    <= S_WB_MEM;
            en_q       <= 1'b1;
            rfwr_q     <= 1'b1;
            rfsel_wr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_MEM_WR: begin
          if (cnt_q == '0) begin
            state_q    <= S_FETCH;
            func_q     <= '0;
            alusel_b_q <= 1'b0;
            rfsel_b_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            en_q  <= (cnt_q == 4'd1);
          end
        end
        S_WB_ALU, S_WB_MEM, S_BR, S_NOP: begin
          state_q    <= S_FETCH;
          func_q     <= '0;
          alusel_b_q <= 1'b0;
          rfsel_b_q  <= 1'b0;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Conditional branch resolves on the live zero flag while in BR.
  assign PC_sel = (state_q == S_BR) &&
                  ((cls_q == CLS_BRA) ||
                   ((cls_q == CLS_BCOND) && (zero ^ (op_q == OP_BNE))));

  assign en       = en_q;
  assign RFwr_en  = rfwr_q;
  assign MEMwr_en = memwr_q;
  assign RFsel_wr = rfsel_wr_q;
  assign ALUsel_B = alusel_b_q;
  assign RFsel_B  = rfsel_b_q;
  assign func     = func_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: three instances (MEM_LAT 1/2/3), one active at a time.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  int          sel = 1;

  always #5 clk = ~clk;

  // {en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, func[3:0]}
  logic [10:0] o1, o2, o3, mon;
  logic        r1, r2, r3, mon_rst;

  assign r1 = reset | (sel != 1);
  assign r2 = reset | (sel != 2);
  assign r3 = reset | (sel != 3);

  always_comb begin
    mon     = o1;
    mon_rst = r1;
    if (sel == 2) begin mon = o2; mon_rst = r2; end
    if (sel == 3) begin mon = o3; mon_rst = r3; end
  end

  control_fsm #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(r1), .instr(instr), .zero(zero),
    .en(o1[10]), .PC_sel(o1[9]), .RFsel_wr(o1[8]), .RFsel_B(o1[7]),
    .RFwr_en(o1[6]), .ALUsel_B(o1[5]), .MEMwr_en(o1[4]), .func(o1[3:0])
  );
  control_fsm #(.MEM_LAT(2)) u_dut2 (
    .clk(clk), .reset(r2), .instr(instr), .zero(zero),
    .en(o2[10]), .PC_sel(o2[9]), .RFsel_wr(o2[8]), .RFsel_B(o2[7]),
    .RFwr_en(o2[6]), .ALUsel_B(o2[5]), .MEMwr_en(o2[4]), .func(o2[3:0])
  );
  control_fsm #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(r3), .instr(instr), .zero(zero),
    .en(o3[10]), .PC_sel(o3[9]), .RFsel_wr(o3[8]), .RFsel_B(o3[7]),
    .RFwr_en(o3[6]), .ALUsel_B(o3[5]), .MEMwr_en(o3[4]), .func(o3[3:0])
  );

  typedef struct {
    string       nm;
    int          en_c;
    int          rf_c;
    int          mem_c;
    logic [10:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   en_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic e, input logic pc, input logic rw,
                                     input logic rb, input logic rf, input logic ab,
                                     input logic mw, input logic [3:0] fn);
    return {e, pc, rw, rb, rf, ab, mw, fn};
  endfunction

  // Monitor: tracks per-instruction strobe timing and pops an expectation on every en.
  logic rst_d = 1'b1;
  always @(posedge clk) rst_d <= mon_rst;

  int cyc = 0, rf_c = 0, mem_c = 0, rf_n = 0, mem_n = 0;
  bit pc_bad = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_d) begin
      chk("reset_outputs", 32'(mon), 32'd0);
      cyc = 1; rf_c = 0; mem_c = 0; rf_n = 0; mem_n = 0; pc_bad = 1'b0;
    end else begin
      cyc++;
      if (mon[6]) begin rf_n++;  if (rf_c == 0)  rf_c = cyc;  end
      if (mon[4]) begin mem_n++; if (mem_c == 0) mem_c = cyc; end
      if (mon[9] && !mon[10]) pc_bad = 1'b1;
      if (mon[10]) begin
        en_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_en", 32'(cyc), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_en_cycle"}, 32'(cyc), 32'(e.en_c));
          chk({e.nm, "_outs"}, 32'(mon), 32'(e.o));
          chk({e.nm, "_rfwr_cycle"}, 32'(rf_c), 32'(e.rf_c));
          chk({e.nm, "_rfwr_count"}, 32'(rf_n), 32'(e.rf_c != 0));
          chk({e.nm, "_memwr_cycle"}, 32'(mem_c), 32'(e.mem_c));
          chk({e.nm, "_memwr_count"}, 32'(mem_n), 32'(e.mem_c != 0));
          chk({e.nm, "_pcsel_outside_en"}, 32'(pc_bad), 32'd0);
        end
        cyc = 0; rf_c = 0; mem_c = 0; rf_n = 0; mem_n = 0; pc_bad = 1'b0;
      end
    end
  end

  task automatic run(input string nm, input logic [31:0] ins, input logic z,
                     input int en_c, input int rfc, input int memc, input logic [10:0] eo);
    exp_t e;
    int   n = 0;
    int   start = en_seen;
    e.nm = nm; e.en_c = en_c; e.rf_c = rfc; e.mem_c = memc; e.o = eo;
    exp_q.push_back(e);
    instr = ins;
    zero  = z;
    while (en_seen == start && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (en_seen == start) begin
      chk({nm, "_timeout"}, 32'(n), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic select(input int k);
    reset = 1'b1;
    sel   = k;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    select(1);

    // Reset arrives at the edge that would enter WB_ALU and is held three edges.
    instr = 32'h8000_0030;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run("r_add",   32'h8000_0030, 1'b0, 4, 4, 0, mk(1,0,0,0,1,0,0,4'b0000));
    run("r_fn6",   32'h8000_0006, 1'b0, 4, 4, 0, mk(1,0,0,0,1,0,0,4'b0110));
    run("addi",    32'hC000_0000, 1'b0, 4, 4, 0, mk(1,0,0,1,1,1,0,4'b0000));
    run("andi",    32'hC800_0000, 1'b0, 4, 4, 0, mk(1,0,0,1,1,1,0,4'b0010));
    run("ori",     32'hCC00_0000, 1'b0, 4, 4, 0, mk(1,0,0,1,1,1,0,4'b0011));
    run("lui",     32'hE400_0000, 1'b0, 4, 4, 0, mk(1,0,0,1,1,1,0,4'b0000));
    run("sw_lat1", 32'h7C00_0000, 1'b0, 4, 0, 4, mk(1,0,0,1,0,1,1,4'b0000));
    run("lb_lat1", 32'h0C00_0000, 1'b0, 5, 5, 0, mk(1,0,1,0,1,1,0,4'b0000));
    run("beq_z1",  32'h0000_0000, 1'b1, 4, 0, 0, mk(1,1,0,1,0,0,0,4'b0001));
    run("bne_z1",  32'h0400_0000, 1'b1, 4, 0, 0, mk(1,0,0,1,0,0,0,4'b0001));
    run("beq_z0",  32'h0000_0000, 1'b0, 4, 0, 0, mk(1,0,0,1,0,0,0,4'b0001));
    run("bne_z0",  32'h0400_0000, 1'b0, 4, 0, 0, mk(1,1,0,1,0,0,0,4'b0001));
    run("b",       32'hFC00_0000, 1'b0, 3, 0, 0, mk(1,1,0,0,0,0,0,4'b0000));
    run("illegal", 32'hA800_0000, 1'b0, 3, 0, 0, mk(1,0,0,0,0,0,0,4'b0000));

    select(2);
    run("sw_lat2", 32'h7C00_0000, 1'b0, 5, 0, 4, mk(1,0,0,1,0,1,0,4'b0000));
    run("sb_lat2", 32'h1C00_0000, 1'b0, 5, 0, 4, mk(1,0,0,1,0,1,0,4'b0000));

    select(3);
    run("lw_lat3", 32'h3C00_0000, 1'b0, 7, 7, 0, mk(1,0,1,0,1,1,0,4'b0000));
    run("sw_lat3", 32'h7C00_0000, 1'b0, 6, 0, 4, mk(1,0,0,1,0,1,0,4'b0000));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
